// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory responder with programmable wait and one-cycle ack
module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;
    logic                    accept;
    logic                    commit;

    logic                    lat_we;
    logic [31:0]             lat_addr;
    logic [31:0]             lat_wdata;

    logic                    c_we;
    logic [31:0]             c_addr;
    logic [31:0]             c_wdata;
    logic                    c_err;
    logic [DEPTH_LOG2-1:0]   c_word;

    logic [31:0]             mem [DEPTH];

    // Next-state, handshake outputs and commit strobe
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = (state == S_IDLE) && reset;
        ack       = (state == S_RESP);
        accept    = ready && req;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_nxt = S_RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT);
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // With zero wait the commit happens on the accepting edge, so the live
    // inputs are used; otherwise the request captured at acceptance is used.
    assign c_we    = (state == S_IDLE) ? we    : lat_we;
    assign c_addr  = (state == S_IDLE) ? addr  : lat_addr;
    assign c_wdata = (state == S_IDLE) ? wdata : lat_wdata;
    assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:DEPTH_LOG2+2] != '0);
    assign c_word  = c_addr[DEPTH_LOG2+1:2];

    // State register, wait counter and request capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end
        end
    end

    // Response registers: updated only at commit, held otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (commit) begin
            if (c_err) begin
                err   <= 1'b1;
                rdata <= 32'd0;
            end else begin
                err <= 1'b0;
                if (!c_we) begin
                    rdata <= mem[c_word];
                end
            end
        end
    end

    // Storage array write; never cleared, and a reset at the commit edge blocks the write
    always_ff @(posedge clk) begin
        if (reset && commit && !c_err && c_we) begin
            mem[c_word] <= c_wdata;
        end
    end
endmodule
